spatial_region_prefetcher: RTL and testbench
============================================

SPATIAL_REGION_PREFETCHER -- requirements
Module: spatial_region_prefetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width in bits.
REQ-002 SHALL have parameter BLK_OFF_W, default 6, byte-offset bits per cache block.
REQ-003 SHALL have parameter REGION_BLKS, default 32, blocks per region and footprint width; power of 2.
REQ-004 SHALL have parameter AT_ENTRIES, default 8, accumulation-table entries; fully associative, LRU.
REQ-005 SHALL have parameter PHT_ENTRIES, default 16, pattern-history-table entries; direct mapped; power of 2.
REQ-006 SHALL have parameter MIN_BLKS, default 2, minimum footprint popcount required to train the PHT.
REQ-007 SHALL have parameter TRIG_ON_MISS, default 1; 1 = only misses allocate AT entries, 0 = any access allocates.
REQ-008 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-010 SHALL have port up_valid_i, input, 1, upper-level access valid.
REQ-011 SHALL have port up_address_i, input, ADDR_W, access byte address.
REQ-012 SHALL have port up_pc_i, input, ADDR_W, PC of the access.
REQ-013 SHALL have port up_miss_i, input, 1, access missed in the upper level.
REQ-014 SHALL have port lo_ready_i, input, 1, lower level accepts a prefetch.
REQ-015 SHALL have port lo_prefetch_valid_o, output, 1, prefetch request valid.
REQ-016 SHALL have port lo_prefetch_address_o, output, ADDR_W, block-aligned prefetch address.
REQ-017 SHALL have port pf_count_o, output, 32, accepted-prefetch counter; saturates at 2^32-1.

Function
REQ-018 Address decode SHALL be: region = addr >> (BLK_OFF_W + log2 REGION_BLKS); offset = addr[BLK_OFF_W +: log2 REGION_BLKS].
REQ-019 PHT key SHALL be up_pc_i XOR offset; index = key[log2 PHT_ENTRIES-1:0]; the remaining key bits form the tag.
REQ-020 On an AT region hit, the block's footprint bit SHALL be set and the entry made MRU; no allocation SHALL occur.
REQ-021 On an AT region miss that is eligible per TRIG_ON_MISS, a trigger SHALL occur: the victim is an invalid entry (lowest index first), otherwise the LRU entry; the new entry stores region, key, and a footprint with only the trigger bit set.
REQ-022 An evicted valid victim with popcount(footprint) >= MIN_BLKS SHALL be written to the PHT at its key index with tag and footprint, replacing the prior occupant; with a lower popcount it SHALL be discarded.
REQ-023 On a trigger, the PHT SHALL be read with the pre-update contents; same-cycle training writes SHALL be visible only from the next cycle.
REQ-024 On a PHT tag hit, the issue engine SHALL load pending = pattern AND NOT trigger bit, together with the trigger region.
REQ-025 The issue engine SHALL have states IDLE and ISSUE; IDLE->ISSUE on a load with pending != 0; ISSUE->IDLE when the last pending bit is accepted.
REQ-026 In ISSUE, lo_prefetch_address_o SHALL be {region, lowest set pending offset, BLK_OFF_W zeros}, with lo_prefetch_valid_o = 1.
REQ-027 A request SHALL be accepted when valid and lo_ready_i are both 1; on acceptance the bit is cleared and pf_count_o increments.
REQ-028 While valid and not ready, the address and valid SHALL be held stable.
REQ-029 A new trigger with a PHT hit during ISSUE SHALL abort the current pattern and load the new one; a transfer accepted in that same cycle still counts.
REQ-030 Pending bits whose blocks are set in the live AT footprint of the same region SHALL be cleared without issue.
REQ-031 The first prefetch valid SHALL be asserted 2 cycles after the trigger access is sampled; thereafter at most one prefetch per cycle.
REQ-032 Accesses with up_valid_i = 0 SHALL cause no state change.

Reset
REQ-033 When rst = 1, all AT/PHT valid bits, footprints and LRU state SHALL clear; the FSM SHALL go to IDLE; lo_prefetch_valid_o = 0, lo_prefetch_address_o = 0, pf_count_o = 0; in-flight patterns SHALL be dropped.

Verification
REQ-034 Reset: assert rst 2 cycles with up_valid_i = 1 -> valid = 0, address = 0, count = 0; no trigger retained.
REQ-035 Train and replay (defaults): PC 0x400 misses at 0x10000, 0x10040, 0x10080, 0x100C0; evict with 8 new regions; PC 0x400 misses at 0x20000 -> prefetches 0x20040, 0x20080, 0x200C0 in order, first 2 cycles later, count = 3.
REQ-036 Below threshold: trained region touches only offset 0 -> no PHT write; replay trigger produces no prefetch.
REQ-037 Backpressure: hold lo_ready_i = 0 for 5 cycles during replay -> 0x20040 held stable, count unchanged; release -> sequence resumes.
REQ-038 Abort: a second trained trigger (region 0x30000) after the first accept -> next address 0x30040; 0x20080 never issued.
REQ-039 Reset mid-ISSUE: rst for 1 cycle -> valid drops next cycle; no further prefetches; repeat trigger yields none (PHT cleared).

Source files
------------

// File: rtl/spatial_region_prefetcher.sv
// Spatial-footprint prefetcher: accumulates per-region block footprints, learns them
// per (PC ^ trigger offset) key, and replays learned footprints on later triggers.
module spatial_region_prefetcher #(
  parameter int ADDR_W       = 64,
  parameter int BLK_OFF_W    = 6,
  parameter int REGION_BLKS  = 32,
  parameter int AT_ENTRIES   = 8,
  parameter int PHT_ENTRIES  = 16,
  parameter int MIN_BLKS     = 2,
  parameter int TRIG_ON_MISS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid_i,
  input  logic [ADDR_W-1:0] up_address_i,
  input  logic [ADDR_W-1:0] up_pc_i,
  input  logic              up_miss_i,
  input  logic              lo_ready_i,
  output logic              lo_prefetch_valid_o,
  output logic [ADDR_W-1:0] lo_prefetch_address_o,
  output logic [31:0]       pf_count_o
);
  localparam int OFF_W = $clog2(REGION_BLKS);
  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int REG_W = ADDR_W - BLK_OFF_W - OFF_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int AGE_W = (AT_ENTRIES > 1) ? $clog2(AT_ENTRIES) : 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Prefetch handshake: a request transfers on a cycle where lo_prefetch_valid_o and
  // lo_ready_i are both high; while valid is high without ready, the request is held.

  logic [REG_W-1:0]       acc_region;
  logic [OFF_W-1:0]       acc_off;
  logic [ADDR_W-1:0]      acc_key;
  logic [REGION_BLKS-1:0] acc_bit;
  logic                   unused_blk_off;

  assign acc_region     = up_address_i[ADDR_W-1 -: REG_W];
  assign acc_off        = up_address_i[BLK_OFF_W +: OFF_W];
  assign acc_key        = up_pc_i ^ ADDR_W'(acc_off);
  assign acc_bit        = REGION_BLKS'(1) << acc_off;
  assign unused_blk_off = ^up_address_i[BLK_OFF_W-1:0];

  logic [AT_ENTRIES-1:0]  at_valid_q;
  logic [REG_W-1:0]       at_region_q [AT_ENTRIES];
  logic [ADDR_W-1:0]      at_key_q    [AT_ENTRIES];
  logic [REGION_BLKS-1:0] at_fp_q     [AT_ENTRIES];
  logic [AGE_W-1:0]       at_age_q    [AT_ENTRIES];

  logic [PHT_ENTRIES-1:0] pht_valid_q;
  logic [TAG_W-1:0]       pht_tag_q [PHT_ENTRIES];
  logic [REGION_BLKS-1:0] pht_pat_q [PHT_ENTRIES];

  logic                   s1_valid_q;
  logic [REG_W-1:0]       s1_region_q;
  logic [REGION_BLKS-1:0] s1_pend_q;

  state_t                 state_q, state_d;
  logic [REG_W-1:0]       issue_region_q, region_d;
  logic [REGION_BLKS-1:0] pending_q, pending_d;
  logic [31:0]            pf_count_q;

  logic                   at_hit, vic_found, trigger, touch, train, pht_hit;
  logic [AGE_W-1:0]       at_hit_idx, victim_idx, touch_idx;
  logic [IDX_W-1:0]       pht_idx, train_idx;
  int                     vic_pop;
  logic [REGION_BLKS-1:0] live_issue, live_load, eff_pend, cur_bit;
  logic [OFF_W-1:0]       cur_off;
  logic                   pf_valid, accept;

  always_comb begin
    at_hit     = 1'b0;
    at_hit_idx = '0;
    vic_found  = 1'b0;
    victim_idx = '0;
    for (int i = 0; i < AT_ENTRIES; i++) begin
      if (at_valid_q[i] && at_region_q[i] == acc_region) begin
        at_hit     = 1'b1;
        at_hit_idx = AGE_W'(i);
      end
      if (!at_valid_q[i] && !vic_found) begin
        vic_found  = 1'b1;
        victim_idx = AGE_W'(i);
      end
    end
    // Ages form a permutation, so exactly one entry holds the oldest age.
    if (!vic_found) begin
      for (int i = 0; i < AT_ENTRIES; i++) begin
        if (at_age_q[i] == AGE_W'(AT_ENTRIES - 1)) victim_idx = AGE_W'(i);
      end
    end
    vic_pop = 0;
    for (int b = 0; b < REGION_BLKS; b++) vic_pop += int'(at_fp_q[victim_idx][b]);
  end

  assign trigger   = up_valid_i && !at_hit && (TRIG_ON_MISS == 0 || up_miss_i);
  assign touch     = (up_valid_i && at_hit) || trigger;
  assign touch_idx = at_hit ? at_hit_idx : victim_idx;
  assign train     = trigger && at_valid_q[victim_idx] && (vic_pop >= MIN_BLKS);
  assign train_idx = at_key_q[victim_idx][IDX_W-1:0];
  assign pht_idx   = acc_key[IDX_W-1:0];
  assign pht_hit   = pht_valid_q[pht_idx] && (pht_tag_q[pht_idx] == acc_key[ADDR_W-1:IDX_W]);

  always_comb begin
    live_issue = '0;
    live_load  = '0;
    for (int i = 0; i < AT_ENTRIES; i++) begin
      if (at_valid_q[i] && at_region_q[i] == issue_region_q) live_issue |= at_fp_q[i];
      if (at_valid_q[i] && at_region_q[i] == s1_region_q)    live_load  |= at_fp_q[i];
    end
  end

  always_comb begin
    eff_pend = pending_q & ~live_issue;
    cur_off  = '0;
    for (int b = REGION_BLKS - 1; b >= 0; b--) begin
      if (eff_pend[b]) cur_off = OFF_W'(b);
    end
    cur_bit   = REGION_BLKS'(1) << cur_off;
    pf_valid  = (state_q == ISSUE) && (|eff_pend);
    accept    = pf_valid && lo_ready_i;
    state_d   = state_q;
    pending_d = pending_q;
    region_d  = issue_region_q;
    case (state_q)
      IDLE: ;
      ISSUE: begin
        pending_d = accept ? (eff_pend & ~cur_bit) : eff_pend;
        if (pending_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh PHT hit replaces whatever pattern is in flight.
    if (s1_valid_q) begin
      pending_d = s1_pend_q & ~live_load;
      region_d  = s1_region_q;
      state_d   = (pending_d != '0) ? ISSUE : IDLE;
    end
  end

  assign lo_prefetch_valid_o   = pf_valid;
  assign lo_prefetch_address_o = pf_valid ? {issue_region_q, cur_off, {BLK_OFF_W{1'b0}}} : '0;
  assign pf_count_o            = pf_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      at_valid_q <= '0;
      for (int i = 0; i < AT_ENTRIES; i++) begin
        at_region_q[i] <= '0;
        at_key_q[i]    <= '0;
        at_fp_q[i]     <= '0;
        at_age_q[i]    <= AGE_W'(i);
      end
    end else if (touch) begin
      for (int i = 0; i < AT_ENTRIES; i++) begin
        if (AGE_W'(i) == touch_idx) at_age_q[i] <= '0;
        else if (at_age_q[i] < at_age_q[touch_idx]) at_age_q[i] <= at_age_q[i] + 1'b1;
      end
      if (at_hit) begin
        at_fp_q[at_hit_idx] <= at_fp_q[at_hit_idx] | acc_bit;
      end else begin
        at_valid_q[victim_idx]  <= 1'b1;
        at_region_q[victim_idx] <= acc_region;
        at_key_q[victim_idx]    <= acc_key;
        at_fp_q[victim_idx]     <= acc_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pht_valid_q <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_tag_q[i] <= '0;
        pht_pat_q[i] <= '0;
      end
    end else if (train) begin
      pht_valid_q[train_idx] <= 1'b1;
      pht_tag_q[train_idx]   <= at_key_q[victim_idx][ADDR_W-1:IDX_W];
      pht_pat_q[train_idx]   <= at_fp_q[victim_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_region_q    <= '0;
      s1_pend_q      <= '0;
      state_q        <= IDLE;
      issue_region_q <= '0;
      pending_q      <= '0;
      pf_count_q     <= '0;
    end else begin
      s1_valid_q     <= trigger && pht_hit;
      s1_region_q    <= acc_region;
      s1_pend_q      <= pht_pat_q[pht_idx] & ~acc_bit;
      state_q        <= state_d;
      issue_region_q <= region_d;
      pending_q      <= pending_d;
      if (accept && pf_count_q != 32'hFFFF_FFFF) pf_count_q <= pf_count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_spatial_region_prefetcher.sv
// Directed bench for spatial_region_prefetcher: reset, below-threshold training,
// train/replay with backpressure, abort with live-footprint skip, reset mid-issue.
module tb_spatial_region_prefetcher;
  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid_i;
  logic [63:0] up_address_i;
  logic [63:0] up_pc_i;
  logic        up_miss_i;
  logic        lo_ready_i;
  logic        lo_prefetch_valid_o;
  logic [63:0] lo_prefetch_address_o;
  logic [31:0] pf_count_o;

  int vectors = 0;
  int miscompares = 0;

  spatial_region_prefetcher dut (
    .clk                   (clk),
    .rst                   (rst),
    .up_valid_i            (up_valid_i),
    .up_address_i          (up_address_i),
    .up_pc_i               (up_pc_i),
    .up_miss_i             (up_miss_i),
    .lo_ready_i            (lo_ready_i),
    .lo_prefetch_valid_o   (lo_prefetch_valid_o),
    .lo_prefetch_address_o (lo_prefetch_address_o),
    .pf_count_o            (pf_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [63:0] addr, input logic [63:0] pc, input logic miss);
    up_valid_i   = 1'b1;
    up_address_i = addr;
    up_pc_i      = pc;
    up_miss_i    = miss;
    tick();
    up_valid_i   = 1'b0;
  endtask

  // Eight single-block regions with a PC whose key never matches the trained keys.
  task automatic fill(input logic [63:0] base);
    for (int i = 0; i < 8; i++) access(base + 64'(i) * 64'h800, 64'h800, 1'b1);
  endtask

  task automatic check_pf(input string tag, input logic v, input logic [63:0] a, input logic [31:0] c);
    check({tag, "_valid"}, 64'(lo_prefetch_valid_o), 64'(v));
    check({tag, "_addr"}, lo_prefetch_address_o, a);
    check({tag, "_count"}, 64'(pf_count_o), 64'(c));
  endtask

  initial begin
    rst          = 1'b1;
    up_valid_i   = 1'b1;
    up_address_i = 64'h10000;
    up_pc_i      = 64'h400;
    up_miss_i    = 1'b1;
    lo_ready_i   = 1'b1;
    tick();
    tick();
    check_pf("reset", 1'b0, 64'h0, 32'd0);
    rst        = 1'b0;
    up_valid_i = 1'b0;
    tick();
    check_pf("reset_post1", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("reset_post2", 1'b0, 64'h0, 32'd0);

    // Only offset 0 touched: popcount 1 never trains.
    access(64'h40000, 64'h505, 1'b1);
    access(64'h40000, 64'h505, 1'b1);
    fill(64'h100_0000);
    access(64'h48040, 64'h504, 1'b1);
    check_pf("below_c0", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("below_c1", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("below_c2", 1'b0, 64'h0, 32'd0);

    // Train footprint 0xF under key 0x400, then evict it into the PHT.
    access(64'h10000, 64'h400, 1'b1);
    access(64'h10040, 64'h400, 1'b1);
    access(64'h10080, 64'h400, 1'b1);
    access(64'h100C0, 64'h400, 1'b1);
    check_pf("train_quiet", 1'b0, 64'h0, 32'd0);
    fill(64'h200_0000);

    access(64'h20000, 64'h400, 1'b0);
    check_pf("hit_no_trig0", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("hit_no_trig1", 1'b0, 64'h0, 32'd0);

    lo_ready_i = 1'b0;
    access(64'h20000, 64'h400, 1'b1);
    check_pf("replay_lat1", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("replay_first", 1'b1, 64'h20040, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_pf("backpressure", 1'b1, 64'h20040, 32'd0);
    end
    lo_ready_i = 1'b1;
    tick();
    check_pf("replay_2nd", 1'b1, 64'h20080, 32'd1);
    tick();
    check_pf("replay_3rd", 1'b1, 64'h200C0, 32'd2);
    tick();
    check_pf("replay_done", 1'b0, 64'h0, 32'd3);

    // Abort: second trigger lands while 0x20080 is stalled.
    fill(64'h300_0000);
    access(64'h20000, 64'h400, 1'b1);
    check_pf("abort_lat1", 1'b0, 64'h0, 32'd3);
    tick();
    check_pf("abort_first", 1'b1, 64'h20040, 32'd3);
    tick();
    check_pf("abort_second", 1'b1, 64'h20080, 32'd4);
    lo_ready_i = 1'b0;
    access(64'h30000, 64'h400, 1'b1);
    check_pf("abort_hold", 1'b1, 64'h20080, 32'd4);
    tick();
    check_pf("abort_new", 1'b1, 64'h30040, 32'd4);
    // Demand touch of 0x30080 removes it from the pending set.
    lo_ready_i = 1'b1;
    access(64'h30080, 64'h400, 1'b1);
    check_pf("live_skip", 1'b1, 64'h300C0, 32'd5);
    tick();
    check_pf("abort_done", 1'b0, 64'h0, 32'd6);

    lo_ready_i = 1'b0;
    access(64'h50000, 64'h400, 1'b1);
    tick();
    check_pf("rstmid_issue", 1'b1, 64'h50040, 32'd6);
    rst = 1'b1;
    tick();
    check_pf("rstmid_drop", 1'b0, 64'h0, 32'd0);
    rst = 1'b0;
    tick();
    check_pf("rstmid_quiet", 1'b0, 64'h0, 32'd0);
    lo_ready_i = 1'b1;
    access(64'h50000, 64'h400, 1'b1);
    check_pf("rstmid_rep0", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("rstmid_rep1", 1'b0, 64'h0, 32'd0);
    tick();
    check_pf("rstmid_rep2", 1'b0, 64'h0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
